// File: rtl/fp_addconv_scheduler.sv
// Shares one DualPathAdderConversion datapath between NUM_REQ requesters: arbitration,
// registered issue, latency-matched tag pipeline and a credit-protected result FIFO.
// Optional: define FP_ADDCONV_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins).
module fp_addconv_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int TAG_W      = 2,
  parameter int SIZE       = 34,
  parameter int LAT        = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [2*NUM_REQ-1:0]      req_conversion_i,
  input  logic [NUM_REQ-1:0]        req_sub_i,
  input  logic [SIZE*NUM_REQ-1:0]   req_a_i,
  input  logic [SIZE*NUM_REQ-1:0]   req_b_i,
  output logic [1:0]                add_conversion_o,
  output logic                      add_sub_o,
  output logic [SIZE-1:0]           add_a_o,
  output logic [SIZE-1:0]           add_b_o,
  input  logic [SIZE-1:0]           add_result_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [TAG_W-1:0]          res_tag_o,
  output logic [SIZE-1:0]           res_number_o,
  output logic                      busy_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, FULL} state_e;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [SIZE-1:0]  num;
  } res_t;

  state_e                         state_q, state_d;
  logic [CW-1:0]                  inflight_q, inflight_d, fifo_cnt_q, fifo_cnt_d;
  logic [CW:0]                    sum_q, sum_d;
  logic [LAT:1]                   vld_pipe_q;
  logic [TAG_W-1:0]               tag_pipe_q [LAT:1];
  logic [AW-1:0]                  wr_ptr_q, rd_ptr_q;
  res_t                           mem_q [FIFO_DEPTH];
  logic                           can_issue, accept, push, pop, gnt_vld;
  logic [TAG_W-1:0]               gnt_idx;
  logic [NUM_REQ-1:0][1:0]        conv_v;
  logic [NUM_REQ-1:0][SIZE-1:0]   a_v, b_v;

  assign a_v = req_a_i;
  assign b_v = req_b_i;

  // Code 11 is folded to a plain FP op before it reaches the adder.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_conv
    assign conv_v[i] = (req_conversion_i[2*i +: 2] == 2'b11) ? 2'b00 : req_conversion_i[2*i +: 2];
  end

`ifdef FP_ADDCONV_SCHED_FIXED_PRIO_EN
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = TAG_W'(i);
      end
    end
  end
`else
  logic [TAG_W-1:0] rr_ptr_q;

  // Scan downward so the last hit is the first valid at or after rr_ptr.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (req_valid_i[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = TAG_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr_ptr_q <= '0;
    else if (accept) rr_ptr_q <= (gnt_idx == TAG_W'(NUM_REQ-1)) ? '0 : gnt_idx + TAG_W'(1);
  end
`endif

  assign sum_q       = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
  assign can_issue   = sum_q < DEPTH_C;
  assign accept      = gnt_vld & can_issue;
  assign req_ready_o = accept ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign push        = vld_pipe_q[LAT];
  assign pop         = res_valid_o & res_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_conversion_o <= '0;
      add_sub_o        <= 1'b0;
      add_a_o          <= '0;
      add_b_o          <= '0;
    end else if (accept) begin
      add_conversion_o <= conv_v[gnt_idx];
      add_sub_o        <= req_sub_i[gnt_idx];
      add_a_o          <= a_v[gnt_idx];
      add_b_o          <= b_v[gnt_idx];
    end
  end

  // Stage LAT lines up with the edge on which add_result_i is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      for (int i = 1; i <= LAT; i++) tag_pipe_q[i] <= '0;
    end else begin
      vld_pipe_q[1] <= accept;
      tag_pipe_q[1] <= gnt_idx;
      for (int i = 2; i <= LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        tag_pipe_q[i] <= tag_pipe_q[i-1];
      end
    end
  end

  assign inflight_d = inflight_q + CW'(accept) - CW'(push);
  assign fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
  assign sum_d      = {1'b0, inflight_d} + {1'b0, fifo_cnt_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= '{tag: tag_pipe_q[LAT], num: add_result_i};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  assign res_valid_o  = fifo_cnt_q != '0;
  assign res_tag_o    = mem_q[rd_ptr_q].tag;
  assign res_number_o = mem_q[rd_ptr_q].num;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY: begin
        if (sum_d == '0)          state_d = IDLE;
        else if (sum_d >= DEPTH_C) state_d = FULL;
      end
      FULL:    if (sum_d < DEPTH_C) state_d = BUSY;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = state_q != IDLE;

  ap_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && fifo_cnt_q == CW'(FIFO_DEPTH)));

endmodule

// File: doc/fp_addconv_scheduler.md
# fp_addconv_scheduler

Arbiter and sequencer that shares one `DualPathAdderConversion` datapath (FP add/sub, FP→int, int→FP) between `NUM_REQ` requesters. It registers the granted operands onto the adder inputs and tracks in-flight operations with a latency-matched tag pipeline. Results are returned through a credit-protected result FIFO with a valid/ready handshake. It sits between the core's operand sources and the single adder instance.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, ≥2.
- `TAG_W`, 2: ceil(log2(`NUM_REQ`)).
- `SIZE`, 34: operand/result width (24 mantissa + 8 exponent + 2 exception).
- `LAT`, 1: clock edges from the issue edge to the edge on which `add_result_i` is sampled. `LAT`=1 for the combinational adder; ≥1.
- `FIFO_DEPTH`, 4: result FIFO entries, power of 2, ≥2.

Ports:
- `clk`, in, 1: clock; all state on rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `req_valid_i`, in, `NUM_REQ`: request pending per requester.
- `req_ready_o`, out, `NUM_REQ`: request accepted this cycle (one-hot or zero).
- `req_conversion_i`, in, 2*`NUM_REQ`: per-requester op. 00 = FP op, 01 = FP→int, 10 = int→FP; 11 is treated as 00.
- `req_sub_i`, in, `NUM_REQ`: subtract select.
- `req_a_i`, `req_b_i`, in, `SIZE`*`NUM_REQ`: operands; requester i occupies slice [i*`SIZE` +: `SIZE`].
- `add_conversion_o`, out, 2; `add_sub_o`, out, 1; `add_a_o`, `add_b_o`, out, `SIZE`: registered adder inputs.
- `add_result_i`, in, `SIZE`: adder result.
- `res_valid_o`, out, 1; `res_ready_i`, in, 1: result handshake.
- `res_tag_o`, out, `TAG_W`: requester index that owns the result.
- `res_number_o`, out, `SIZE`: result.
- `busy_o`, out, 1: state is not IDLE.

## Operation
- Credit: `inflight` (count of tag-pipeline valid bits) + `fifo_count` < `FIFO_DEPTH` ⇒ `can_issue`.
- Arbitration: round-robin pointer `rr_ptr`. Grant goes to the first i with `req_valid_i[i]`, searching from `rr_ptr` upward with wrap. `req_ready_o[i]` = grant[i] & `can_issue`; ready depends combinationally on valid. On accept, `rr_ptr` ← grant index + 1 (mod `NUM_REQ`). Otherwise `rr_ptr` holds.
- Issue (accept edge): `add_*_o` load the granted requester's fields; conversion 11 is loaded as 00. A bit `{1, tag}` enters the `LAT`-stage tag pipeline. With no accept, `add_*_o` hold their values and a 0 valid bit enters the pipeline.
- Capture: when tag-pipeline stage `LAT` is valid, `{tag, add_result_i}` is pushed into the FIFO on that edge. Credits guarantee the FIFO never overflows; overflow is an assertion failure.
- Output: `res_valid_o` = FIFO not empty; `res_tag_o`/`res_number_o` = FIFO head. Pop on `res_valid_o & res_ready_i`. No bypass: a push into an empty FIFO is visible the next cycle.
- A simultaneous push and pop leaves `fifo_count` unchanged. A pop frees a credit usable in the next cycle, not the same cycle.
- FSM:
  - IDLE: no in-flight ops and FIFO empty. Goes to BUSY on accept.
  - BUSY: ops in flight or results pending. Goes to FULL when `can_issue`=0. Returns to IDLE when `inflight`=0 and `fifo_count`=0 after a pop, with no accept that cycle.
  - FULL: all `req_ready_o`=0. Returns to BUSY on the edge after a pop restores credit.
- Width rules: `inflight` and `fifo_count` are counters of width log2(`FIFO_DEPTH`)+1. FIFO pointers are log2(`FIFO_DEPTH`) bits and wrap naturally.

## Timing
- Reset values: `req_ready_o`=0 (combinational; all-zero when no valid), `add_*_o`=0, `res_valid_o`=0, `res_tag_o`=0, `res_number_o`=0, `busy_o`=0. Also `rr_ptr`=0, tag pipeline cleared, FIFO empty, state IDLE.
- Latency: accept on edge E ⇒ result pushed on edge E+`LAT` ⇒ `res_valid_o` high after edge E+`LAT`.
- Throughput: one accept per cycle while credits remain.
- Reset mid-operation: in-flight ops and FIFO contents are discarded immediately (asynchronous). Requesters must re-issue.

## Configuration
- `FP_ADDCONV_SCHED_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins, and `rr_ptr` is removed.
  - Undefined (default): round-robin as described above.

## Test plan
- Single request: requester 2 issues a=+1.5, b=+2.25 FP add with `LAT`=1 ⇒ `req_ready_o`=4'b0100 for one cycle; two edges later `res_valid_o`=1, `res_tag_o`=2, result encodes +3.75.
- Fairness: all 4 valid continuously, `res_ready_i`=1 ⇒ grants in order 0,1,2,3,0,…; no requester waits more than 3 cycles. With the macro defined ⇒ requester 0 is granted every cycle.
- Backpressure: `res_ready_i`=0, `FIFO_DEPTH`=4, `LAT`=1 ⇒ exactly 4 accepts, then `req_ready_o`=0 and `busy_o`=1 (FULL). A single pop ⇒ exactly one more accept on the following cycle.
- Conversions: requester 1 sends int→FP of 32'd7 and requester 3 sends FP→int of -2.0 ⇒ tags 1 and 3 return in issue order with the correct values. Conversion code 11 behaves as an FP add.
- Simultaneous events: push and pop on the same edge at `fifo_count`=2 ⇒ count stays 2. With `LAT`=3 and 3 ops in flight, the last pop ⇒ state returns to IDLE only after all 3 results are popped.
- Reset: assert `rst_n`=0 with 2 ops in flight and 1 FIFO entry ⇒ outputs immediately take their reset values; after release, no stale `res_valid_o` appears.
